// File: rtl/bit_stats.sv
// Multi-cycle bit statistics: popcount, zero count, leading/trailing zeros, one CHUNK slice per cycle.
// Optional macro BIT_STATS_PARITY_EN adds the out_parity port (XOR of the accepted operand).
module bit_stats #(
  parameter int BITS  = 16,
  parameter int CHUNK = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [BITS-1:0]            in_data,
  input  logic [1:0]                 in_mode,
  output logic                       out_valid,
  input  logic                       out_ready,
`ifdef BIT_STATS_PARITY_EN
  output logic                       out_parity,
`endif
  output logic [$clog2(BITS+1)-1:0]  out_result
);

  localparam int RW  = $clog2(BITS+1);
  localparam int NCH = BITS / CHUNK;
  localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t            state, state_nxt;
  logic [BITS-1:0]   data_r;
  logic [1:0]        mode_r;
  logic [RW-1:0]     acc, acc_nxt, result_fin, res_r;
  logic [IW-1:0]     idx;
  logic              seen, seen_nxt, last;
  logic [CHUNK-1:0]  chunk;

  function automatic logic [RW-1:0] popc(input logic [CHUNK-1:0] c);
    logic [RW-1:0] n;
    n = '0;
    for (int i = 0; i < CHUNK; i++) n = n + RW'(c[i]);
    return n;
  endfunction

  // Zeros below the lowest set bit; CHUNK when the slice is empty.
  function automatic logic [RW-1:0] tzc(input logic [CHUNK-1:0] c);
    logic [RW-1:0] n;
    n = RW'(CHUNK);
    for (int i = CHUNK-1; i >= 0; i--) if (c[i]) n = RW'(i);
    return n;
  endfunction

  function automatic int msbp(input logic [CHUNK-1:0] c);
    int p;
    p = 0;
    for (int i = 0; i < CHUNK; i++) if (c[i]) p = i;
    return p;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = BUSY;
      end
      BUSY: if (last) state_nxt = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Slice datapath: current chunk folded into the running count
  always_comb begin
    chunk    = CHUNK'(data_r >> (int'(idx) * CHUNK));
    last     = (idx == IW'(NCH - 1));
    acc_nxt  = acc;
    seen_nxt = seen;
    case (mode_r)
      2'b00: acc_nxt = acc + popc(chunk);
      2'b01: acc_nxt = acc + (RW'(CHUNK) - popc(chunk));
      2'b10: begin
        // Slices arrive LSB first, so the latest non-empty slice holds the highest one.
        if (|chunk) begin
          acc_nxt  = RW'(BITS - 1 - (int'(idx) * CHUNK + msbp(chunk)));
          seen_nxt = 1'b1;
        end
      end
      default: begin
        if (!seen) begin
          acc_nxt  = acc + tzc(chunk);
          seen_nxt = |chunk;
        end
      end
    endcase
    result_fin = (mode_r == 2'b10 && !seen_nxt) ? RW'(BITS) : acc_nxt;
  end

  always_ff @(posedge clk) begin
    if (state == IDLE && in_valid) begin
      data_r <= in_data;
      mode_r <= in_mode;
      acc    <= '0;
      idx    <= '0;
      seen   <= 1'b0;
    end else if (state == BUSY) begin
      acc  <= acc_nxt;
      seen <= seen_nxt;
      idx  <= IW'(idx + 1'b1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst)                     res_r <= '0;
    else if (state == BUSY && last) res_r <= result_fin;
  end

  assign out_result = res_r;

`ifdef BIT_STATS_PARITY_EN
  logic par, par_nxt, par_out;

  assign par_nxt = par ^ (^chunk);

  always_ff @(posedge clk) begin
    if (state == IDLE && in_valid) par <= 1'b0;
    else if (state == BUSY)        par <= par_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst)                       par_out <= 1'b0;
    else if (state == BUSY && last) par_out <= par_nxt;
  end

  assign out_parity = par_out;
`endif

endmodule

// File: tb/tb_bit_stats.sv
// Randomized self-checking bench for bit_stats (BITS=16, CHUNK=4) against a whole-vector reference model.
module tb_bit_stats;

  localparam int BITS  = 16;
  localparam int CHUNK = 4;
  localparam int RW    = $clog2(BITS+1);

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [BITS-1:0] in_data;
  logic [1:0]      in_mode;
  logic            out_valid;
  logic            out_ready;
  logic [RW-1:0]   out_result;
`ifdef BIT_STATS_PARITY_EN
  logic            out_parity;
`endif

  int checks   = 0;
  int failures = 0;

  bit_stats #(.BITS(BITS), .CHUNK(CHUNK)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_mode(in_mode),
    .out_valid(out_valid), .out_ready(out_ready),
`ifdef BIT_STATS_PARITY_EN
    .out_parity(out_parity),
`endif
    .out_result(out_result)
  );

  always #5 clk = ~clk;

  // Reference model over the whole operand.
  function automatic int model(input logic [BITS-1:0] v, input logic [1:0] m);
    int ones, lz, tz;
    bit hit;
    ones = 0;
    for (int i = 0; i < BITS; i++) ones += int'(v[i]);
    lz = 0; hit = 0;
    for (int i = BITS-1; i >= 0; i--) begin
      if (v[i]) hit = 1;
      else if (!hit) lz++;
    end
    tz = 0; hit = 0;
    for (int i = 0; i < BITS; i++) begin
      if (v[i]) hit = 1;
      else if (!hit) tz++;
    end
    case (m)
      2'b00:   return ones;
      2'b01:   return BITS - ones;
      2'b10:   return lz;
      default: return tz;
    endcase
  endfunction

  // Drives one operand from IDLE through release; returns result, parity and accept-to-valid latency.
  task automatic run_op(input logic [BITS-1:0] d, input logic [1:0] m,
                        output int res, output bit par, output int lat);
    int guard;
    in_data = d; in_mode = m; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = 16'($urandom);
    in_mode  = 2'($urandom);
    lat = 1; guard = 0;
    while (!out_valid && guard < 50) begin
      @(posedge clk); #1;
      lat++; guard++;
    end
    res = int'(out_result);
`ifdef BIT_STATS_PARITY_EN
    par = out_parity;
`else
    par = 1'b0;
`endif
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_result !== '0) begin
      failures++;
      $display("FAIL reset_state: got rdy=%b vld=%b res=%0d, expected rdy=1 vld=0 res=0",
               in_ready, out_valid, out_result);
    end
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_vectors();
    logic [BITS-1:0] dv [9] = '{16'hF0F1, 16'hF0F1, 16'h0000, 16'h0000, 16'hFFFF,
                                16'hFFFF, 16'h0100, 16'h0100, 16'h8000};
    logic [1:0]      mv [9] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3, 2'd2};
    int              ev [9] = '{9, 7, 16, 16, 16, 0, 7, 8, 0};
    int res, lat;
    bit par;
    for (int i = 0; i < 9; i++) begin
      run_op(dv[i], mv[i], res, par, lat);
      checks++;
      if (res !== ev[i] || lat !== 5) begin
        failures++;
        $display("FAIL directed_%0d: data=%h mode=%0d got res=%0d lat=%0d, expected res=%0d lat=5",
                 i, dv[i], mv[i], res, lat, ev[i]);
      end
    end
    for (int i = 0; i < 40; i++) begin
      logic [BITS-1:0] d;
      logic [1:0]      m;
      d = (i % 3 == 0) ? (16'h1 << $urandom_range(BITS-1, 0)) : 16'($urandom);
      m = 2'($urandom);
      run_op(d, m, res, par, lat);
      checks++;
      if (res !== model(d, m) || lat !== 5) begin
        failures++;
        $display("FAIL random_%0d: data=%h mode=%0d got res=%0d lat=%0d, expected res=%0d lat=5",
                 i, d, m, res, lat, model(d, m));
      end
    end
  endtask

  task automatic test_backpressure();
    logic [BITS-1:0] d;
    int exp, guard;
    d = 16'hA5C3;
    exp = model(d, 2'b00);
    in_data = d; in_mode = 2'b00; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    guard = 0;
    while (!out_valid && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    in_valid = 1'b1; in_data = 16'hFFFF; in_mode = 2'b01;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_result !== RW'(exp)) begin
        failures++;
        $display("FAIL hold_%0d: got vld=%b rdy=%b res=%0d, expected vld=1 rdy=0 res=%0d",
                 c, out_valid, in_ready, out_result, exp);
      end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL release: got vld=%b rdy=%b, expected vld=0 rdy=1", out_valid, in_ready);
    end
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL no_accept_in_done: got rdy=%b, expected rdy=1", in_ready);
    end
  endtask

  task automatic test_reset_busy();
    int res, lat;
    bit par;
    in_data = 16'hFFFF; in_mode = 2'b00; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    checks++;
    if (out_valid !== 1'b0 || out_result !== '0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_busy: got vld=%b res=%0d rdy=%b, expected vld=0 res=0 rdy=1",
               out_valid, out_result, in_ready);
    end
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b0) begin
        failures++;
        $display("FAIL reset_discard_%0d: got vld=%b, expected vld=0", c, out_valid);
      end
    end
    run_op(16'h0003, 2'b00, res, par, lat);
    checks++;
    if (res !== 2 || lat !== 5) begin
      failures++;
      $display("FAIL after_reset: got res=%0d lat=%0d, expected res=2 lat=5", res, lat);
    end
  endtask

  task automatic test_back_to_back();
    logic [BITS-1:0] q[$];
    logic [BITS-1:0] d;
    int last_t, nres;
    last_t = -1; nres = 0;
    in_mode = 2'b00; out_ready = 1'b1; in_valid = 1'b1;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (in_ready) begin
        in_data = 16'($urandom);
        q.push_back(in_data);
      end
      @(posedge clk); #1;
      if (out_valid) begin
        d = (q.size() > 0) ? q.pop_front() : 16'h0;
        checks++;
        if (out_result !== RW'(model(d, 2'b00))) begin
          failures++;
          $display("FAIL b2b_result: data=%h got %0d expected %0d", d, out_result, model(d, 2'b00));
        end
        if (last_t >= 0) begin
          checks++;
          if (cyc - last_t !== 6) begin
            failures++;
            $display("FAIL b2b_spacing: got %0d cycles expected 6", cyc - last_t);
          end
        end
        last_t = cyc;
        nres++;
      end
    end
    in_valid = 1'b0;
    checks++;
    if (nres < 6) begin
      failures++;
      $display("FAIL b2b_count: got %0d results expected at least 6", nres);
    end
    repeat (8) @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

`ifdef BIT_STATS_PARITY_EN
  task automatic test_parity();
    int res, lat;
    bit par;
    logic [BITS-1:0] d;
    run_op(16'h0007, 2'b00, res, par, lat);
    checks++;
    if (par !== 1'b1) begin
      failures++;
      $display("FAIL parity_0007: got %b expected 1", par);
    end
    run_op(16'h0003, 2'b00, res, par, lat);
    checks++;
    if (par !== 1'b0) begin
      failures++;
      $display("FAIL parity_0003: got %b expected 0", par);
    end
    for (int i = 0; i < 10; i++) begin
      d = 16'($urandom);
      run_op(d, 2'($urandom), res, par, lat);
      checks++;
      if (par !== (^d)) begin
        failures++;
        $display("FAIL parity_rand: data=%h got %b expected %b", d, par, ^d);
      end
    end
  endtask
`endif

  initial begin
    rst = 1'b0; in_valid = 1'b0; in_data = '0; in_mode = '0; out_ready = 1'b0;
    test_reset();
    test_vectors();
    test_backpressure();
    test_reset_busy();
    test_back_to_back();
`ifdef BIT_STATS_PARITY_EN
    test_parity();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bit_stats.md
BIT_STATS -- requirements
Module: bit_stats

Interface
REQ-001 SHALL have parameter BITS, default 16: input vector width; legal values are multiples of CHUNK, and BITS >= CHUNK.
REQ-002 SHALL have parameter CHUNK, default 4: bits examined per cycle; legal values are powers of two, 1..BITS.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-low reset.
REQ-005 SHALL have port in_valid, input, 1 bit: in_data and in_mode are valid.
REQ-006 SHALL have port in_ready, output, 1 bit: the block accepts an operand this cycle.
REQ-007 SHALL have port in_data, input, BITS bits: the operand vector.
REQ-008 SHALL have port in_mode, input, 2 bits: 00 = count ones, 01 = count zeros, 10 = leading zeros from the MSB, 11 = trailing zeros from the LSB.
REQ-009 SHALL have port out_valid, output, 1 bit: out_result is valid.
REQ-010 SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-011 SHALL have port out_result, output, $clog2(BITS+1) bits: the computed count.
REQ-012 SHALL have port out_parity, output, 1 bit: XOR of the accepted operand; present only with BIT_STATS_PARITY_EN (REQ-030).

Function
REQ-013 SHALL use a three-state FSM: IDLE, BUSY, DONE.
REQ-014 IDLE: in_ready=1, out_valid=0; in_valid=1 SHALL capture in_data/in_mode into internal registers, clear the accumulator and chunk index, and move to BUSY.
REQ-015 BUSY: in_ready=0, out_valid=0; each cycle SHALL process one CHUNK slice, LSB slice first (index 0..BITS/CHUNK-1).
REQ-016 The BUSY slice order SHALL be fixed (LSB first) for all modes; the leading-zero mode derives its result from the position of the highest set bit seen.
REQ-017 BUSY SHALL last exactly BITS/CHUNK cycles, then move to DONE.
REQ-018 Total latency from the accept edge to out_valid=1 SHALL be BITS/CHUNK+1 cycles (defaults: 5).
REQ-019 DONE: out_valid=1, in_ready=0, out_result stable; out_ready=1 SHALL move to IDLE on the next edge.
REQ-020 DONE SHALL hold out_result and out_valid indefinitely while out_ready=0 (backpressure).
REQ-021 No operand is accepted in DONE; back-to-back throughput SHALL be one result per BITS/CHUNK+2 cycles.
REQ-022 Modes 00 and 01 SHALL sum to BITS for the same operand.
REQ-023 An all-zero operand SHALL give BITS for mode 10 and mode 11.
REQ-024 An all-one operand SHALL give 0 for modes 01, 10 and 11.
REQ-025 Arithmetic SHALL be unsigned and never overflow; the accumulator is $clog2(BITS+1) bits wide.
REQ-026 in_data and in_mode changes after acceptance SHALL have no effect on the operation in flight.
REQ-027 out_ready while not in DONE SHALL be ignored.

Reset
REQ-028 With rst=0 at a rising edge, the block SHALL go to IDLE and set out_valid=0, out_result=0, out_parity=0 and in_ready=1 on the following cycle, regardless of the current state.
REQ-029 A reset during BUSY or DONE SHALL discard the operation in flight; no partial result SHALL be presented.

Configuration
REQ-030 The macro BIT_STATS_PARITY_EN SHALL control the parity feature:
- When defined: port out_parity exists, is accumulated per chunk during BUSY, and is valid with out_valid and held like out_result.
- When undefined: the port and its logic are absent; all other behaviour is unchanged.

Verification
REQ-031 BITS=16, CHUNK=4, in_data=16'hF0F1, mode 00 -> out_result=9 exactly 5 cycles after the accept edge; mode 01 -> 7.
REQ-032 in_data=16'h0000 -> mode 10 = 16 and mode 11 = 16; in_data=16'hFFFF -> mode 00 = 16, mode 01 = 0.
REQ-033 in_data=16'h0100 -> mode 10 = 7, mode 11 = 8; in_data=16'h8000 -> mode 10 = 0.
REQ-034 out_ready held 0 for 10 cycles in DONE -> out_result stable, in_ready=0, the new in_valid is not accepted; release -> IDLE on the next edge.
REQ-035 rst=0 asserted during the 2nd BUSY cycle -> next cycle IDLE, out_valid=0, out_result=0; the next operand 16'h0003 in mode 00 -> 2.
REQ-036 With BIT_STATS_PARITY_EN defined, in_data=16'h0007 -> out_parity=1; in_data=16'h0003 -> out_parity=0.
